coin_credit_fsm: RTL and testbench
==================================

// Module: coin_credit_fsm
// PURPOSE
//   Vending-machine credit controller. Detects coin insertions, accumulates credit 0..7,
//   requests a dispense once credit reaches PRICE, then returns change. Drives the 3-bit
//   current-credit code cs that the seven-segment coin display decodes (cs = number of coin units).
// PARAMETERS
//   PRICE       5   item price in coin units (1..7)
//   CREDIT_MAX  7   saturation limit of credit; must fit 3 bits, >= PRICE
// PORTS
//   clk           in   1  system clock, all logic on rising edge
//   rst_n         in   1  synchronous active-low reset, sampled on rising clk
//   coin1         in   1  1-unit coin switch, level, already synchronous to clk
//   coin2         in   1  2-unit coin switch, level, already synchronous to clk
//   refund        in   1  refund button, level (present only with COIN_REFUND_EN)
//   dispense_ack  in   1  dispenser finished, 1-cycle pulse
//   cs            out  3  current credit code to display, 0..7
//   dispense      out  1  dispense request, held until ack
//   change        out  3  change amount, valid with change_valid
//   change_valid  out  1  1-cycle pulse, change is returned
//   coin_reject   out  1  1-cycle pulse, detected coin edge was not accepted
// BEHAVIOUR
//   - Reset: state IDLE, credit=0, cs=0, dispense=0, change=0, change_valid=0, coin_reject=0,
//     edge-detector history = 0. Reset mid-vend discards credit and drops dispense the next edge.
//   - Coin events = rising edges of coin1/coin2 (previous-cycle registered compare). A held
//     level counts once. Credit updates the cycle after the edge is sampled (1-cycle latency).
//   - States: IDLE -> VEND -> CHANGE -> IDLE.
//     IDLE: accept coin. new = credit + value. If new > CREDIT_MAX: credit unchanged,
//       coin_reject=1. Else credit <= new, and if new >= PRICE go to VEND.
//     VEND: dispense=1, cs holds credit. Coin edges rejected (coin_reject). Stays until
//       dispense_ack=1; on ack -> CHANGE, dispense drops the same edge.
//     CHANGE: change <= credit - PRICE, change_valid=1 for exactly one cycle, credit <= 0,
//       cs=0 from the next cycle; coin edges rejected; -> IDLE.
//   - Simultaneous coin1 and coin2 edges: coin2 accepted (if it fits), coin1 rejected.
//   - dispense_ack outside VEND is ignored.
//   - change holds its last value between pulses; only meaningful with change_valid.
//   - cs always equals the registered credit; no combinational path from inputs to outputs.
//   - Arithmetic in 4 bits internally so credit + 2 never wraps before the limit compare.
// CONFIGURATION
//   COIN_REFUND_EN defined: refund port exists; rising edge of refund in IDLE with
//     credit > 0 -> change=credit, change_valid=1 for one cycle, credit <= 0, no dispense.
//     Refund edge together with a coin edge: refund wins, coin rejected. Ignored in VEND/CHANGE.
//   COIN_REFUND_EN undefined: no refund port, no refund logic; credit leaves only via vend.
// STRUCTURE
//   Package vend_pkg: state localparams ST_IDLE/ST_VEND/ST_CHANGE (2-bit), coin values
//     COIN1_VAL=1, COIN2_VAL=2, credit width CREDIT_W=3.
//   Sub-module edge_pulse (1-bit rising-edge detector with synchronous active-low reset),
//     instantiated per coin1, coin2, refund.
// TESTING (PRICE=5, CREDIT_MAX=7)
//   - Reset with coin1 held high -> all outputs 0; release then raise -> one credit, cs=1.
//   - coin2,coin2,coin1 edges -> cs 2,4,5; dispense=1 cycle after 3rd edge; ack -> change=0 pulse, cs=0.
//   - coin2 x3 -> cs=6, dispense=1; ack -> change_valid with change=1, next cycle cs=0.
//   - coin1 x4 then coin2 -> cs=6 vend; coin1 edge during VEND -> coin_reject=1, cs stays 6.
//   - Simultaneous coin1+coin2 edge at credit 0 -> cs=2, coin_reject=1 same cycle.
//   - COIN_REFUND_EN: coin2, coin1, refund -> change=3, change_valid=1, cs=0, dispense never 1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the coin credit controller: state codes, coin values, credit width.
package vend_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VEND   = 2'd1;
    localparam logic [1:0] ST_CHANGE = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        VEND   = ST_VEND,
        CHANGE = ST_CHANGE
    } state_t;

    localparam int CREDIT_W = 3;

    localparam logic [3:0] COIN1_VAL = 4'd1;
    localparam logic [3:0] COIN2_VAL = 4'd2;

    // coin2 has priority when both coins arrive in the same cycle
    function automatic logic [3:0] coin_value(input logic c1, input logic c2);
        if (c2) begin
            return COIN2_VAL;
        end else if (c1) begin
            return COIN1_VAL;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/coin_credit_fsm_edge_pulse.sv
// Module edge_pulse: 1-bit rising-edge detector against the previous-cycle registered level.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = din & ~prev_q;

endmodule

// File: rtl/coin_credit_fsm.sv
// Vending credit controller: accumulates coin credit, requests dispense, returns change.
// Optional refund button enabled by defining COIN_REFUND_EN.
module coin_credit_fsm
    import vend_pkg::*;
#(
    parameter int PRICE      = 5,
    parameter int CREDIT_MAX = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin1,
    input  logic                coin2,
`ifdef COIN_REFUND_EN
    input  logic                refund,
`endif
    input  logic                dispense_ack,
    output logic [CREDIT_W-1:0] cs,
    output logic                dispense,
    output logic [CREDIT_W-1:0] change,
    output logic                change_valid,
    output logic                coin_reject
);

    localparam logic [3:0]          PRICE4 = 4'(PRICE);
    localparam logic [3:0]          MAX4   = 4'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0] PRICE3 = CREDIT_W'(PRICE);

    logic c1_pulse;
    logic c2_pulse;

    edge_pulse u_edge_c1 (.clk(clk), .rst_n(rst_n), .din(coin1), .pulse(c1_pulse));
    edge_pulse u_edge_c2 (.clk(clk), .rst_n(rst_n), .din(coin2), .pulse(c2_pulse));

`ifdef COIN_REFUND_EN
    logic rf_pulse;
    edge_pulse u_edge_rf (.clk(clk), .rst_n(rst_n), .din(refund), .pulse(rf_pulse));
`endif

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                change_valid_q, change_valid_d;
    logic                coin_reject_q, coin_reject_d;

    logic       any_coin;
    logic [3:0] sum4;

    // 4-bit sum so credit + 2 cannot wrap before the limit compare
    assign any_coin = c1_pulse | c2_pulse;
    assign sum4     = {1'b0, credit_q} + coin_value(c1_pulse, c2_pulse);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        dispense_d     = dispense_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
`ifdef COIN_REFUND_EN
                if (rf_pulse && (credit_q != '0)) begin
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    coin_reject_d  = any_coin;
                end else
`endif
                if (any_coin) begin
                    coin_reject_d = c1_pulse & c2_pulse;
                    if (sum4 > MAX4) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = sum4[CREDIT_W-1:0];
                        if (sum4 >= PRICE4) begin
                            state_d    = VEND;
                            dispense_d = 1'b1;
                        end
                    end
                end
            end
            VEND: begin
                coin_reject_d = any_coin;
                if (dispense_ack) begin
                    state_d        = CHANGE;
                    dispense_d     = 1'b0;
                    change_d       = credit_q - PRICE3;
                    change_valid_d = 1'b1;
                end
            end
            CHANGE: begin
                coin_reject_d = any_coin;
                credit_d      = '0;
                state_d       = IDLE;
            end
            default: begin
                state_d    = IDLE;
                credit_d   = '0;
                dispense_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= dispense_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
        end
    end

    assign cs           = credit_q;
    assign dispense     = dispense_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Self-checking bench for coin_credit_fsm (PRICE=5, CREDIT_MAX=7): directed vector table plus random run.
module tb_coin_credit_fsm;

    localparam int PRICE      = 5;
    localparam int CREDIT_MAX = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin1 = 1'b0;
    logic       coin2 = 1'b0;
    logic       refund = 1'b0;
    logic       dispense_ack = 1'b0;
    logic [2:0] cs;
    logic       dispense;
    logic [2:0] change;
    logic       change_valid;
    logic       coin_reject;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    coin_credit_fsm #(.PRICE(PRICE), .CREDIT_MAX(CREDIT_MAX)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .coin1(coin1),
        .coin2(coin2),
`ifdef COIN_REFUND_EN
        .refund(refund),
`endif
        .dispense_ack(dispense_ack),
        .cs(cs),
        .dispense(dispense),
        .change(change),
        .change_valid(change_valid),
        .coin_reject(coin_reject)
    );

    typedef struct {
        bit       r, c1, c2, ak, rf;
        int       e_cs;
        bit       e_d, e_cv;
        int       e_ch;
        bit       e_rej;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit r, bit c1, bit c2, bit ak, bit rf,
                                int e_cs, bit e_d, bit e_cv, int e_ch, bit e_rej);
        vec_t v;
        v.r = r; v.c1 = c1; v.c2 = c2; v.ak = ak; v.rf = rf;
        v.e_cs = e_cs; v.e_d = e_d; v.e_cv = e_cv; v.e_ch = e_ch; v.e_rej = e_rej;
        return v;
    endfunction

    // Reference model: credit as an integer, phase 0=collecting, 1=awaiting ack, 2=paying out
    int m_credit = 0, m_phase = 0, m_change = 0;
    bit m_disp = 0, m_cv = 0, m_rej = 0;
    bit m_p1 = 0, m_p2 = 0, m_pr = 0;

`ifdef COIN_REFUND_EN
    localparam bit REFUND_ON = 1'b1;
`else
    localparam bit REFUND_ON = 1'b0;
`endif

    task automatic model_step(input bit r, input bit i1, input bit i2, input bit ia, input bit ir);
        bit e1, e2, er;
        int v;
        if (!r) begin
            m_credit = 0; m_phase = 0; m_change = 0;
            m_disp = 0; m_cv = 0; m_rej = 0;
            m_p1 = 0; m_p2 = 0; m_pr = 0;
            return;
        end
        e1 = i1 && !m_p1; e2 = i2 && !m_p2; er = ir && !m_pr;
        m_p1 = i1; m_p2 = i2; m_pr = ir;
        m_cv = 0; m_rej = 0;
        if (m_phase == 0) begin
            if (REFUND_ON && er && m_credit > 0) begin
                m_change = m_credit; m_cv = 1; m_credit = 0; m_rej = e1 || e2;
            end else if (e1 || e2) begin
                v = e2 ? 2 : 1;
                m_rej = e1 && e2;
                if (m_credit + v > CREDIT_MAX) begin
                    m_rej = 1;
                end else begin
                    m_credit += v;
                    if (m_credit >= PRICE) begin
                        m_phase = 1; m_disp = 1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            m_rej = e1 || e2;
            if (ia) begin
                m_phase = 2; m_disp = 0; m_cv = 1; m_change = m_credit - PRICE;
            end
        end else begin
            m_rej = e1 || e2;
            m_credit = 0; m_phase = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit i1, input bit i2, input bit ia, input bit ir);
        @(negedge clk);
        rst_n = r; coin1 = i1; coin2 = i2; dispense_ack = ia; refund = ir;
        @(posedge clk);
        model_step(r, i1, i2, ia, ir);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int e_cs, input bit e_d, input bit e_cv,
                            input int e_ch, input bit e_rej);
        chk({tag, " cs"}, int'(cs), e_cs);
        chk({tag, " dispense"}, int'(dispense), int'(e_d));
        chk({tag, " change_valid"}, int'(change_valid), int'(e_cv));
        chk({tag, " coin_reject"}, int'(coin_reject), int'(e_rej));
        if (e_cv) chk({tag, " change"}, int'(change), e_ch);
    endtask

    initial begin
        // Reset with coin1 held high: everything stays zero
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk_outs("reset_hold", 0, 0, 0, 0, 0);
            chk("reset_change", int'(change), 0);
        end
        cyc(1, 0, 0, 0, 0);
        chk_outs("post_reset", 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk_outs("first_coin1", 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_outs("first_coin1_rel", 1, 0, 0, 0, 0);

        vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
        // coin2, coin2, coin1 -> exact price, zero change
        vq.push_back(mk(1,0,1,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,0,1,0,0, 4,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 4,0,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 5,1,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 5,1,0,0,0));
        vq.push_back(mk(1,0,0,1,0, 5,0,1,0,0));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
        vq.push_back(mk(1,0,0,1,0, 0,0,0,0,0));
        // coin2 x3 -> credit 6, change 1, coin during payout rejected
        vq.push_back(mk(1,0,1,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,0,1,0,0, 4,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 4,0,0,0,0));
        vq.push_back(mk(1,0,1,0,0, 6,1,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 6,1,0,0,0));
        vq.push_back(mk(1,0,0,1,0, 6,0,1,1,0));
        vq.push_back(mk(1,1,0,0,0, 0,0,0,0,1));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
        // coin1 x4 then coin2 -> vend at 6, coin during VEND rejected
        for (int i = 1; i <= 4; i++) begin
            vq.push_back(mk(1,1,0,0,0, i,0,0,0,0));
            vq.push_back(mk(1,0,0,0,0, i,0,0,0,0));
        end
        vq.push_back(mk(1,0,1,0,0, 6,1,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 6,1,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 6,1,0,0,1));
        vq.push_back(mk(1,0,0,0,0, 6,1,0,0,0));
        vq.push_back(mk(1,0,0,1,0, 6,0,1,1,0));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
        // simultaneous edges, held level, reset mid-vend
        vq.push_back(mk(1,1,1,0,0, 2,0,0,0,1));
        vq.push_back(mk(1,0,0,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 3,0,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 3,0,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 3,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 3,0,0,0,0));
        vq.push_back(mk(1,0,1,0,0, 5,1,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 5,1,0,0,0));
        vq.push_back(mk(0,0,0,0,0, 0,0,0,0,0));
        vq.push_back(mk(1,0,0,1,0, 0,0,0,0,0));
`ifdef COIN_REFUND_EN
        vq.push_back(mk(1,0,1,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,1,0,0,0, 3,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 3,0,0,0,0));
        vq.push_back(mk(1,0,0,0,1, 0,0,1,3,0));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
        vq.push_back(mk(1,0,1,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,0,0,0,0, 2,0,0,0,0));
        vq.push_back(mk(1,1,0,0,1, 0,0,1,2,1));
        vq.push_back(mk(1,0,0,0,0, 0,0,0,0,0));
`endif

        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].c1, vq[i].c2, vq[i].ak, vq[i].rf);
            chk_outs($sformatf("vec%0d", i), vq[i].e_cs, vq[i].e_d, vq[i].e_cv,
                     vq[i].e_ch, vq[i].e_rej);
        end

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0));
            chk_outs("rand", m_credit, m_disp, m_cv, m_change, m_rej);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
